// File: rtl/name_writer.sv
// rtl/name_writer.sv - tile name RAM write-side controller with cursor and hardware clear
module name_writer #(
    parameter int COLS       = 40,
    parameter int ROWS       = 30,
    parameter int TILE_W     = 2,
    parameter int ADDR_W     = 11,
    parameter int BLANK_GATE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [7:0]        cmd_data,
    input  logic              blank,
    output logic              busy,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [TILE_W-1:0] ram_wdata,
    output logic [5:0]        cur_col,
    output logic [4:0]        cur_row
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    localparam logic [1:0] OP_PUT     = 2'd0;
    localparam logic [1:0] OP_SET_COL = 2'd1;
    localparam logic [1:0] OP_SET_ROW = 2'd2;
    localparam logic [1:0] OP_CLEAR   = 2'd3;

    localparam logic [5:0]        COL_MAX   = 6'(COLS - 1);
    localparam logic [4:0]        ROW_MAX   = 5'(ROWS - 1);
    localparam logic [7:0]        COL_LIM8  = 8'(COLS - 1);
    localparam logic [7:0]        ROW_LIM8  = 8'(ROWS - 1);
    localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);

    logic [0:0]        state_q, state_d;
    logic [5:0]        col_q, col_d;
    logic [4:0]        row_q, row_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [TILE_W-1:0] fill_q, fill_d;
    // Set once the final clear write has been issued; the following cycle
    // is spent draining so busy stays high while that write is on the port.
    logic              last_q, last_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [TILE_W-1:0] wdata_q, wdata_d;

    logic              go;
    logic              accept;
    logic [ADDR_W-1:0] cur_addr;

    assign go        = (BLANK_GATE == 0) || blank;
    assign cmd_ready = ~rst & (state_q == ST_IDLE) & go;
    assign accept    = cmd_valid & cmd_ready;

    assign busy      = (state_q == ST_CLEAR);
    assign ram_we    = we_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign cur_col   = col_q;
    assign cur_row   = row_q;

    // Linear name-RAM address of the cursor, kept at full address width.
    always_comb begin
        cur_addr = ADDR_W'(row_q) * COLS_A + ADDR_W'(col_q);
    end

    // Command decode, cursor update and clear sequencing.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;
        last_d  = last_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_PUT: begin
                            we_d    = 1'b1;
                            addr_d  = cur_addr;
                            wdata_d = cmd_data[TILE_W-1:0];
                            if (col_q == COL_MAX) begin
                                col_d = 6'd0;
                                row_d = (row_q == ROW_MAX) ? 5'd0 : row_q + 5'd1;
                            end else begin
                                col_d = col_q + 6'd1;
                            end
                        end
                        OP_SET_COL: begin
                            col_d = (cmd_data > COL_LIM8) ? COL_MAX : cmd_data[5:0];
                        end
                        OP_SET_ROW: begin
                            row_d = (cmd_data > ROW_LIM8) ? ROW_MAX : cmd_data[4:0];
                        end
                        OP_CLEAR: begin
                            fill_d  = cmd_data[TILE_W-1:0];
                            cnt_d   = '0;
                            last_d  = 1'b0;
                            col_d   = 6'd0;
                            row_d   = 5'd0;
                            state_d = ST_CLEAR;
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end
            end
            ST_CLEAR: begin
                if (last_q) begin
                    last_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (go) begin
                    we_d    = 1'b1;
                    addr_d  = cnt_q;
                    wdata_d = fill_q;
                    if (cnt_q == LAST_ADDR) begin
                        last_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any clear in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            col_q   <= 6'd0;
            row_q   <= 5'd0;
            cnt_q   <= '0;
            fill_q  <= '0;
            last_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

endmodule

// File: tb/tb_name_writer.sv
// tb/tb_name_writer.sv - directed self-checking bench for name_writer
module tb_name_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_data;
    logic        blank;
    logic        busy;
    logic        ram_we;
    logic [10:0] ram_addr;
    logic [1:0]  ram_wdata;
    logic [5:0]  cur_col;
    logic [4:0]  cur_row;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    name_writer dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .blank     (blank),
        .busy      (busy),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .cur_col   (cur_col),
        .cur_row   (cur_row)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one command, wait (bounded) for cmd_ready, let it be accepted.
    task automatic send(input logic [1:0] op, input logic [7:0] data);
        int n;
        n         = 0;
        cmd_op    = op;
        cmd_data  = data;
        cmd_valid = 1'b1;
        #1;
        while (!cmd_ready && n < 100) begin
            tick();
            n++;
        end
        if (!cmd_ready) check("send_ready", 32'(cmd_ready), 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic pb;

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = 8'd0; blank = 1'b1;
        tick();
        tick();
        check("rst_ready", 32'(cmd_ready), 0);
        check("rst_we",    32'(ram_we),    0);
        check("rst_addr",  32'(ram_addr),  0);
        check("rst_wdata", 32'(ram_wdata), 0);
        check("rst_busy",  32'(busy),      0);
        check("rst_col",   32'(cur_col),   0);
        check("rst_row",   32'(cur_row),   0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", 32'(cmd_ready), 1);

        // PUT 3 at (0,0)
        send(2'd0, 8'd3);
        check("put_we",   32'(ram_we),    1);
        check("put_addr", 32'(ram_addr),  0);
        check("put_data", 32'(ram_wdata), 3);
        check("put_col",  32'(cur_col),   1);
        check("put_row",  32'(cur_row),   0);
        tick();
        check("idle_we", 32'(ram_we), 0);

        // Wrap from the bottom-right corner
        send(2'd1, 8'd39);
        check("setcol_col", 32'(cur_col), 39);
        check("setcol_we",  32'(ram_we),  0);
        send(2'd2, 8'd29);
        check("setrow_row", 32'(cur_row), 29);
        send(2'd0, 8'd1);
        check("wrap_we",   32'(ram_we),    1);
        check("wrap_addr", 32'(ram_addr),  1199);
        check("wrap_data", 32'(ram_wdata), 1);
        check("wrap_col",  32'(cur_col),   0);
        check("wrap_row",  32'(cur_row),   0);

        // Clamping
        send(2'd1, 8'd200);
        check("clamp_col", 32'(cur_col), 39);
        send(2'd2, 8'd100);
        check("clamp_row", 32'(cur_row), 29);

        // Back-to-back PUTs across a row end
        send(2'd1, 8'd38);
        send(2'd2, 8'd5);
        cmd_op = 2'd0; cmd_data = 8'd2; cmd_valid = 1'b1;
        tick();
        check("b2b0_we",   32'(ram_we),    1);
        check("b2b0_addr", 32'(ram_addr),  238);
        check("b2b0_data", 32'(ram_wdata), 2);
        check("b2b0_col",  32'(cur_col),   39);
        cmd_data = 8'd1;
        tick();
        check("b2b1_we",   32'(ram_we),    1);
        check("b2b1_addr", 32'(ram_addr),  239);
        check("b2b1_data", 32'(ram_wdata), 1);
        check("b2b1_col",  32'(cur_col),   0);
        check("b2b1_row",  32'(cur_row),   6);
        cmd_valid = 1'b0;
        tick();
        check("b2b_idle_we", 32'(ram_we), 0);

        // Blank gating: held command must wait for blank
        blank = 1'b0; cmd_op = 2'd0; cmd_data = 8'd2; cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("gate_ready", 32'(cmd_ready), 0);
            tick();
            check("gate_we", 32'(ram_we), 0);
        end
        blank = 1'b1;
        #1;
        check("gate_rise_ready", 32'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
        check("gate_we_after", 32'(ram_we),    1);
        check("gate_addr",     32'(ram_addr),  240);
        check("gate_data",     32'(ram_wdata), 2);
        check("gate_col",      32'(cur_col),   1);

        // CLEAR with blank held high
        send(2'd3, 8'd2);
        check("clr_busy0",  32'(busy),      1);
        check("clr_ready0", 32'(cmd_ready), 0);
        check("clr_we0",    32'(ram_we),    0);
        check("clr_col0",   32'(cur_col),   0);
        check("clr_row0",   32'(cur_row),   0);
        n = 0;
        for (int i = 0; i < 1400; i++) begin
            tick();
            if (ram_we) begin
                check("clr_wr", 32'({busy, ram_wdata, ram_addr}), 32'({1'b1, 2'd2, 11'(n)}));
                n++;
            end else if (!busy) begin
                break;
            end
        end
        check("clr_count", 32'(n), 1200);
        check("clr_busy_end", 32'(busy), 0);
        check("clr_we_end", 32'(ram_we), 0);
        check("clr_ready_end", 32'(cmd_ready), 1);
        check("clr_col_end", 32'(cur_col), 0);
        check("clr_row_end", 32'(cur_row), 0);

        // CLEAR with blank toggling every 50 cycles
        send(2'd3, 8'd1);
        n  = 0;
        pb = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            tick();
            if (ram_we) begin
                check("stall_wr", 32'({pb, ram_wdata, ram_addr}), 32'({1'b1, 2'd1, 11'(n)}));
                n++;
            end else if (!busy) begin
                break;
            end
            blank = (((i + 1) / 50) % 2 == 0);
            pb    = blank;
        end
        blank = 1'b1;
        #1;
        check("stall_count", 32'(n), 1200);
        check("stall_busy_end", 32'(busy), 0);
        check("stall_ready_end", 32'(cmd_ready), 1);

        // Reset in the middle of a clear
        send(2'd3, 8'd3);
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (ram_we) n++;
            if (n == 500) break;
        end
        check("mid_count", 32'(n), 500);
        rst = 1'b1;
        tick();
        check("mid_we",    32'(ram_we),    0);
        check("mid_busy",  32'(busy),      0);
        check("mid_addr",  32'(ram_addr),  0);
        check("mid_wdata", 32'(ram_wdata), 0);
        check("mid_ready", 32'(cmd_ready), 0);
        rst   = 1'b0;
        blank = 1'b0;
        #1;
        check("mid_ready_noblank", 32'(cmd_ready), 0);
        blank = 1'b1;
        #1;
        check("mid_ready_blank", 32'(cmd_ready), 1);
        send(2'd0, 8'd1);
        check("post_we",   32'(ram_we),    1);
        check("post_addr", 32'(ram_addr),  0);
        check("post_data", 32'(ram_wdata), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
